// File: rtl/fwd_scoreboard_pkg.sv
// Shared types and helpers for the forwarding scoreboard: pipeline-entry layout,
// the register-file select code and a constant-foldable ceil(log2).
package fwd_scoreboard_pkg;

    // Register addresses are zero-extended into this field; RADDR must not exceed it.
    localparam int RADDR_MAX = 8;
    localparam int SEL_RF    = 0;

    typedef logic [RADDR_MAX-1:0] reg_t;

    typedef struct packed {
        logic vld;
        reg_t rd;
        logic wr;
        logic ld;
    } entry_t;

    function automatic int clog2(input int n);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) w = i + 1;
        end
        return w;
    endfunction

    // Register 0 is hard-wired, so an entry writing it never supplies a value.
    function automatic logic live_match(input entry_t e, input reg_t r);
        return e.vld & e.wr & (e.rd != '0) & (e.rd == r);
    endfunction

endpackage

// File: rtl/fwd_scoreboard_if.sv
// ID-stage request / hazard-response bundle between the pipeline control and the scoreboard.
interface fwd_scoreboard_if #(
    parameter int NSRC  = 2,
    parameter int RADDR = 5,
    parameter int SELW  = 2
);
    logic                  id_valid;
    logic [NSRC*RADDR-1:0] id_rs;
    logic [RADDR-1:0]      id_rd;
    logic                  id_regwrite;
    logic                  id_memread;
    logic                  id_branch;
    logic                  hold;
    logic                  flush;
    logic                  stall;
    logic [NSRC*SELW-1:0]  ex_fwd_sel;
    logic [NSRC*SELW-1:0]  br_fwd_sel;
    logic [15:0]           stall_cnt;

    modport master (
        output id_valid, id_rs, id_rd, id_regwrite, id_memread, id_branch, hold, flush,
        input  stall, ex_fwd_sel, br_fwd_sel, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rd, id_regwrite, id_memread, id_branch, hold, flush,
        output stall, ex_fwd_sel, br_fwd_sel, stall_cnt
    );
endinterface

// File: rtl/fwd_match_pri.sv
// Priority match of one source register against the post-ID table: the youngest
// live writer in stages 1..NSTAGE-1 wins; stage 0 is never a forwarding source.
module fwd_match_pri
    import fwd_scoreboard_pkg::*;
#(
    parameter int  NSTAGE    = 3,
    parameter bit  LD_FILTER = 1'b0,
    localparam int SELW      = clog2(NSTAGE)
) (
    input  reg_t                  i_src,
    input  entry_t [NSTAGE-1:0]   i_tab,
    output logic   [SELW-1:0]     o_sel
);

    // Walk oldest to youngest so the smallest matching index is the last one written.
    always_comb begin
        o_sel = SELW'(SEL_RF);
        for (int k = NSTAGE - 1; k >= 1; k--) begin
            if (live_match(i_tab[k], i_src) && !(LD_FILTER && i_tab[k].ld)) begin
                o_sel = SELW'(k);
            end
        end
    end

endmodule

// File: rtl/fwd_scoreboard.sv
// Forwarding/hazard scoreboard: tracks destination info of in-flight instructions,
// generates ALU and branch-comparator forwarding selects and the ID stall.
module fwd_scoreboard
    import fwd_scoreboard_pkg::*;
#(
    parameter int  NSTAGE = 3,
    parameter int  NSRC   = 2,
    parameter int  RADDR  = 5,
    localparam int SELW   = clog2(NSTAGE)
) (
    input  logic               clk,
    input  logic               rst_n,
    fwd_scoreboard_if.slave    sb
);

    entry_t [NSTAGE-1:0] r_tab;
    reg_t   [NSRC-1:0]   r_ex_rs;
    logic   [15:0]       r_stall_cnt;

    reg_t   [NSRC-1:0]   w_id_rs;
    logic   [NSRC-1:0]   w_hazard;
    logic                w_stall;
    logic                w_bubble;

    generate
        for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
            assign w_id_rs[gi] = reg_t'(sb.id_rs[gi*RADDR +: RADDR]);

            fwd_match_pri #(
                .NSTAGE    (NSTAGE),
                .LD_FILTER (1'b0)
            ) u_ex_match (
                .i_src (r_ex_rs[gi]),
                .i_tab (r_tab),
                .o_sel (sb.ex_fwd_sel[gi*SELW +: SELW])
            );

            // The branch comparator cannot take load data still in flight, hence the filter.
            fwd_match_pri #(
                .NSTAGE    (NSTAGE),
                .LD_FILTER (1'b1)
            ) u_br_match (
                .i_src (w_id_rs[gi]),
                .i_tab (r_tab),
                .o_sel (sb.br_fwd_sel[gi*SELW +: SELW])
            );

            assign w_hazard[gi] =
                (live_match(r_tab[0], w_id_rs[gi]) & (r_tab[0].ld | sb.id_branch)) |
                (sb.id_branch & r_tab[1].ld & live_match(r_tab[1], w_id_rs[gi]));
        end
    endgenerate

    assign w_stall      = sb.id_valid & ~sb.flush & (|w_hazard);
    assign w_bubble     = w_stall | sb.flush;
    assign sb.stall     = w_stall;
    assign sb.stall_cnt = r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tab       <= '0;
            r_ex_rs     <= '0;
            r_stall_cnt <= '0;
        end else if (!sb.hold) begin
            for (int k = 1; k < NSTAGE; k++) begin
                r_tab[k] <= r_tab[k-1];
            end
            // A bubble carries no sources either, so EX stops asking for forwarded data.
            if (w_bubble) begin
                r_tab[0] <= '0;
                r_ex_rs  <= '0;
            end else begin
                r_tab[0].vld <= sb.id_valid;
                r_tab[0].rd  <= reg_t'(sb.id_rd);
                r_tab[0].wr  <= sb.id_regwrite;
                r_tab[0].ld  <= sb.id_memread;
                r_ex_rs      <= w_id_rs;
            end
            if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Self-checking bench: NSTAGE=3 and NSTAGE=5 scoreboards driven in lockstep and
// compared against an instruction-history reference model.
module tb_fwd_scoreboard;

    localparam int NSRC  = 2;
    localparam int RADDR = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                  id_valid, id_regwrite, id_memread, id_branch, hold, flush;
    logic [NSRC*RADDR-1:0] id_rs;
    logic [RADDR-1:0]      id_rd;

    fwd_scoreboard_if #(.NSRC(NSRC), .RADDR(RADDR), .SELW(2)) if3 ();
    fwd_scoreboard_if #(.NSRC(NSRC), .RADDR(RADDR), .SELW(3)) if5 ();

    assign if3.id_valid = id_valid;    assign if5.id_valid = id_valid;
    assign if3.id_rs = id_rs;          assign if5.id_rs = id_rs;
    assign if3.id_rd = id_rd;          assign if5.id_rd = id_rd;
    assign if3.id_regwrite = id_regwrite; assign if5.id_regwrite = id_regwrite;
    assign if3.id_memread = id_memread;   assign if5.id_memread = id_memread;
    assign if3.id_branch = id_branch;  assign if5.id_branch = id_branch;
    assign if3.hold = hold;            assign if5.hold = hold;
    assign if3.flush = flush;          assign if5.flush = flush;

    fwd_scoreboard #(.NSTAGE(3), .NSRC(NSRC), .RADDR(RADDR)) u3 (.clk(clk), .rst_n(rst_n), .sb(if3));
    fwd_scoreboard #(.NSTAGE(5), .NSRC(NSRC), .RADDR(RADDR)) u5 (.clk(clk), .rst_n(rst_n), .sb(if5));

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: per DUT, the instructions issued in the last ns[d] slots (0 = newest).
    bit         mvld [2][8];
    logic [4:0] mrd  [2][8];
    bit         mwr  [2][8];
    bit         mld  [2][8];
    logic [4:0] mrs  [2][NSRC];
    int         mcnt [2];
    int         ns   [2] = '{3, 5};
    int         sw   [2] = '{2, 3};

    function automatic logic [4:0] src(int s);
        return id_rs[s*RADDR +: RADDR];
    endfunction

    function automatic bit writes(int d, int k, logic [4:0] r);
        return mvld[d][k] && mwr[d][k] && (mrd[d][k] != 5'd0) && (mrd[d][k] == r);
    endfunction

    function automatic bit exp_stall(int d);
        if (!id_valid || flush) return 1'b0;
        for (int s = 0; s < NSRC; s++) begin
            if (writes(d, 0, src(s)) && (mld[d][0] || id_branch)) return 1'b1;
            if (id_branch && writes(d, 1, src(s)) && mld[d][1]) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic int exp_sel(int d, bit for_branch);
        int v = 0;
        for (int s = 0; s < NSRC; s++) begin
            int sel = 0;
            logic [4:0] r = for_branch ? src(s) : mrs[d][s];
            for (int k = 1; k < ns[d]; k++) begin
                if (sel == 0 && writes(d, k, r) && !(for_branch && mld[d][k])) sel = k;
            end
            v = v | (sel << (s * sw[d]));
        end
        return v;
    endfunction

    task automatic model_clear();
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 8; k++) begin
                mvld[d][k] = 0; mrd[d][k] = '0; mwr[d][k] = 0; mld[d][k] = 0;
            end
            for (int s = 0; s < NSRC; s++) mrs[d][s] = '0;
            mcnt[d] = 0;
        end
    endtask

    task automatic set_id(bit v, logic [4:0] r0, logic [4:0] r1, logic [4:0] rd, bit wr, bit ld, bit br);
        id_valid = v; id_rs = {r1, r0}; id_rd = rd;
        id_regwrite = wr; id_memread = ld; id_branch = br;
    endtask

    task automatic tick();
        bit st [2];
        for (int d = 0; d < 2; d++) st[d] = exp_stall(d);
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (!hold) begin
                for (int k = ns[d] - 1; k >= 1; k--) begin
                    mvld[d][k] = mvld[d][k-1]; mrd[d][k] = mrd[d][k-1];
                    mwr[d][k] = mwr[d][k-1];   mld[d][k] = mld[d][k-1];
                end
                if (flush || st[d]) begin
                    mvld[d][0] = 0; mrd[d][0] = '0; mwr[d][0] = 0; mld[d][0] = 0;
                    for (int s = 0; s < NSRC; s++) mrs[d][s] = '0;
                end else begin
                    mvld[d][0] = id_valid; mrd[d][0] = id_rd;
                    mwr[d][0] = id_regwrite; mld[d][0] = id_memread;
                    for (int s = 0; s < NSRC; s++) mrs[d][s] = src(s);
                end
                if (st[d] && mcnt[d] < 65535) mcnt[d]++;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        set_id(0, 0, 0, 0, 0, 0, 0);
        hold = 0; flush = 0;
        rst_n = 1'b0;
        model_clear();
        #2 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_cmp++; if (if3.stall !== 1'b0) begin n_bad++; $display("FAIL rst_stall: got %0b want 0", if3.stall); end
        n_cmp++; if (if3.ex_fwd_sel !== 4'h0) begin n_bad++; $display("FAIL rst_ex_sel: got %0h want 0", if3.ex_fwd_sel); end
        n_cmp++; if (if3.br_fwd_sel !== 4'h0) begin n_bad++; $display("FAIL rst_br_sel: got %0h want 0", if3.br_fwd_sel); end
        n_cmp++; if (if5.stall_cnt !== 16'd0) begin n_bad++; $display("FAIL rst_cnt: got %0d want 0", if5.stall_cnt); end
        $display("test_reset done");
    endtask

    task automatic test_alu_forward();
        do_reset();
        set_id(1, 1, 2, 3, 1, 0, 0); tick();
        set_id(1, 3, 0, 10, 1, 0, 0);
        @(negedge clk);
        n_cmp++; if (if3.stall !== 1'b0) begin n_bad++; $display("FAIL fwd_nostall: got %0b want 0", if3.stall); end
        tick();
        set_id(1, 3, 7, 11, 1, 0, 0);
        @(negedge clk);
        n_cmp++; if (if3.ex_fwd_sel !== 4'h1) begin n_bad++; $display("FAIL fwd_sel1: got %0h want 1", if3.ex_fwd_sel); end
        tick();
        @(negedge clk);
        n_cmp++; if (if3.ex_fwd_sel !== 4'h2) begin n_bad++; $display("FAIL fwd_sel2: got %0h want 2", if3.ex_fwd_sel); end
        n_cmp++; if (if5.ex_fwd_sel !== 6'h2) begin n_bad++; $display("FAIL fwd_sel2_n5: got %0h want 2", if5.ex_fwd_sel); end
        $display("test_alu_forward done");
    endtask

    task automatic test_load_use();
        do_reset();
        set_id(1, 1, 0, 4, 1, 1, 0); tick();
        set_id(1, 4, 2, 12, 1, 0, 0);
        @(negedge clk);
        n_cmp++; if (if3.stall !== 1'b1) begin n_bad++; $display("FAIL lu_stall: got %0b want 1", if3.stall); end
        tick();
        @(negedge clk);
        n_cmp++; if (if3.stall !== 1'b0) begin n_bad++; $display("FAIL lu_release: got %0b want 0", if3.stall); end
        n_cmp++; if (if3.ex_fwd_sel !== 4'h0) begin n_bad++; $display("FAIL lu_bubble_sel: got %0h want 0", if3.ex_fwd_sel); end
        n_cmp++; if (if3.stall_cnt !== 16'd1) begin n_bad++; $display("FAIL lu_cnt: got %0d want 1", if3.stall_cnt); end
        tick();
        @(negedge clk);
        n_cmp++; if (if3.ex_fwd_sel !== 4'h2) begin n_bad++; $display("FAIL lu_sel: got %0h want 2", if3.ex_fwd_sel); end
        $display("test_load_use done");
    endtask

    task automatic test_branch();
        do_reset();
        set_id(1, 1, 2, 5, 1, 0, 0); tick();
        set_id(1, 5, 0, 0, 0, 0, 1);
        @(negedge clk);
        n_cmp++; if (if3.stall !== 1'b1) begin n_bad++; $display("FAIL br_stall: got %0b want 1", if3.stall); end
        tick();
        @(negedge clk);
        n_cmp++; if (if3.stall !== 1'b0) begin n_bad++; $display("FAIL br_release: got %0b want 0", if3.stall); end
        n_cmp++; if (if3.br_fwd_sel !== 4'h1) begin n_bad++; $display("FAIL br_sel: got %0h want 1", if3.br_fwd_sel); end
        $display("test_branch done");
    endtask

    task automatic test_r0();
        do_reset();
        set_id(1, 1, 0, 0, 1, 1, 0); tick();
        set_id(1, 0, 0, 9, 1, 0, 1);
        @(negedge clk);
        n_cmp++; if (if3.stall !== 1'b0) begin n_bad++; $display("FAIL r0_stall: got %0b want 0", if3.stall); end
        n_cmp++; if (if3.br_fwd_sel !== 4'h0) begin n_bad++; $display("FAIL r0_br: got %0h want 0", if3.br_fwd_sel); end
        tick();
        @(negedge clk);
        n_cmp++; if (if3.ex_fwd_sel !== 4'h0) begin n_bad++; $display("FAIL r0_ex: got %0h want 0", if3.ex_fwd_sel); end
        $display("test_r0 done");
    endtask

    task automatic test_hold();
        do_reset();
        set_id(1, 1, 0, 4, 1, 1, 0); tick();
        set_id(1, 4, 2, 12, 1, 0, 0);
        hold = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++; if (if3.stall !== 1'b1 || if3.stall_cnt !== 16'd0) begin
                n_bad++; $display("FAIL hold_frozen: got stall=%0b cnt=%0d want 1/0", if3.stall, if3.stall_cnt);
            end
            tick();
        end
        hold = 0;
        @(negedge clk);
        n_cmp++; if (if3.stall !== 1'b1) begin n_bad++; $display("FAIL hold_resume: got %0b want 1", if3.stall); end
        tick();
        @(negedge clk);
        n_cmp++; if (if3.stall !== 1'b0 || if3.stall_cnt !== 16'd1) begin
            n_bad++; $display("FAIL hold_after: got stall=%0b cnt=%0d want 0/1", if3.stall, if3.stall_cnt);
        end
        tick();
        @(negedge clk);
        n_cmp++; if (if3.ex_fwd_sel !== 4'h2) begin n_bad++; $display("FAIL hold_sel: got %0h want 2", if3.ex_fwd_sel); end
        $display("test_hold done");
    endtask

    task automatic test_flush_and_deep();
        do_reset();
        set_id(1, 1, 0, 4, 1, 1, 0); tick();
        set_id(1, 4, 0, 12, 1, 0, 0);
        flush = 1;
        @(negedge clk);
        n_cmp++; if (if3.stall !== 1'b0) begin n_bad++; $display("FAIL flush_stall: got %0b want 0", if3.stall); end
        tick();
        flush = 0;
        set_id(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        n_cmp++; if (if3.ex_fwd_sel !== 4'h0 || if3.stall_cnt !== 16'd0) begin
            n_bad++; $display("FAIL flush_bubble: got sel=%0h cnt=%0d want 0/0", if3.ex_fwd_sel, if3.stall_cnt);
        end
        do_reset();
        set_id(1, 1, 0, 9, 1, 0, 0); tick();
        set_id(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) tick();
        set_id(1, 9, 0, 13, 1, 0, 0); tick();
        @(negedge clk);
        n_cmp++; if (if5.ex_fwd_sel !== 6'h4) begin n_bad++; $display("FAIL deep_sel4: got %0h want 4", if5.ex_fwd_sel); end
        n_cmp++; if (if3.ex_fwd_sel !== 4'h0) begin n_bad++; $display("FAIL deep_dropped: got %0h want 0", if3.ex_fwd_sel); end
        $display("test_flush_and_deep done");
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        set_id(1, 1, 0, 4, 1, 1, 0); tick();
        set_id(1, 4, 0, 7, 1, 1, 0);
        @(negedge clk);
        n_cmp++; if (if3.stall !== 1'b1) begin n_bad++; $display("FAIL mid_pre: got %0b want 1", if3.stall); end
        rst_n = 1'b0;
        model_clear();
        #1;
        n_cmp++; if (if3.stall !== 1'b0 || if3.stall_cnt !== 16'd0) begin
            n_bad++; $display("FAIL mid_async: got stall=%0b cnt=%0d want 0/0", if3.stall, if3.stall_cnt);
        end
        #1 rst_n = 1'b1;
        tick();
        set_id(1, 7, 0, 8, 1, 0, 0);
        @(negedge clk);
        n_cmp++; if (if3.stall !== 1'b1) begin n_bad++; $display("FAIL mid_post_load: got %0b want 1", if3.stall); end
        $display("test_reset_mid_stall done");
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 300; i++) begin
            set_id(1'($urandom_range(4) != 0), 5'($urandom_range(7)), 5'($urandom_range(7)),
                   5'($urandom_range(7)), 1'($urandom_range(3) != 0), 1'($urandom_range(2) == 0),
                   1'($urandom_range(4) == 0));
            hold  = ($urandom_range(9) == 0);
            flush = ($urandom_range(9) == 0);
            @(negedge clk);
            n_cmp++; if (if3.stall !== exp_stall(0) || if5.stall !== exp_stall(1)) begin
                n_bad++; $display("FAIL rnd_stall[%0d]: got %0b/%0b want %0b/%0b", i, if3.stall, if5.stall, exp_stall(0), exp_stall(1));
            end
            n_cmp++; if (int'(if3.ex_fwd_sel) !== exp_sel(0, 0) || int'(if5.ex_fwd_sel) !== exp_sel(1, 0)) begin
                n_bad++; $display("FAIL rnd_ex[%0d]: got %0h/%0h want %0h/%0h", i, if3.ex_fwd_sel, if5.ex_fwd_sel, exp_sel(0, 0), exp_sel(1, 0));
            end
            if (!exp_stall(0)) begin
                n_cmp++; if (int'(if3.br_fwd_sel) !== exp_sel(0, 1)) begin
                    n_bad++; $display("FAIL rnd_br3[%0d]: got %0h want %0h", i, if3.br_fwd_sel, exp_sel(0, 1));
                end
            end
            if (!exp_stall(1)) begin
                n_cmp++; if (int'(if5.br_fwd_sel) !== exp_sel(1, 1)) begin
                    n_bad++; $display("FAIL rnd_br5[%0d]: got %0h want %0h", i, if5.br_fwd_sel, exp_sel(1, 1));
                end
            end
            n_cmp++; if (int'(if3.stall_cnt) !== mcnt[0] || int'(if5.stall_cnt) !== mcnt[1]) begin
                n_bad++; $display("FAIL rnd_cnt[%0d]: got %0d/%0d want %0d/%0d", i, if3.stall_cnt, if5.stall_cnt, mcnt[0], mcnt[1]);
            end
            $display("txn %0d: v=%0b rs=%0h rd=%0d hold=%0b flush=%0b stall=%0b/%0b ex=%0h/%0h cnt=%0d",
                     i, id_valid, id_rs, id_rd, hold, flush, if3.stall, if5.stall,
                     if3.ex_fwd_sel, if5.ex_fwd_sel, if3.stall_cnt);
            tick();
        end
        hold = 0; flush = 0;
    endtask

    initial begin
        set_id(0, 0, 0, 0, 0, 0, 0);
        hold = 0; flush = 0;
        model_clear();
        test_reset();
        test_alu_forward();
        test_load_use();
        test_branch();
        test_r0();
        test_hold();
        test_flush_and_deep();
        test_reset_mid_stall();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
